baccarat_round_fsm: RTL and testbench

Baccarat round controller that deals cards in strict baccarat order. It accumulates player and dealer hands, computes both scores modulo 10, and applies the natural and third-card rules. It sits directly upstream of the betting/balance stage and feeds it pscore, dscore and the endround strobe, whose rising edge settles the bet. Cards come from an external card generator on new_card, one card per accepted step.

---
 rtl/baccarat_round_fsm.sv | 130 +++++++++++++
 tb/tb_baccarat_round_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_round_fsm.sv
// baccarat_round_fsm: deals one baccarat round in strict order and applies the natural and third-card rules
// Ports:
//   clk             round clock, all state changes on the rising edge
//   reset           asynchronous, active-low
//   step            advance request, one action per clock with step=1
//   new_card        rank from the card generator (1=A .. 13=K)
//   pcard1..pcard3  player card ranks, 0 = not dealt
//   dcard1..dcard3  dealer card ranks, 0 = not dealt
//   pscore, dscore  hand scores 0..9
//   endround        high while the round is finished
//   pwin, dwin, tie result flags, valid only while endround is high
module baccarat_round_fsm #(
   parameter logic [3:0] NATURAL_MIN      = 4'd8,
   parameter logic [3:0] PLAYER_STAND_MIN = 4'd6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   input  logic [3:0] new_card,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] dcard1,
   output logic [3:0] dcard2,
   output logic [3:0] dcard3,
   output logic [3:0] pscore,
   output logic [3:0] dscore,
   output logic       endround,
   output logic       pwin,
   output logic       dwin,
   output logic       tie
);

   typedef enum logic [2:0] {P1, D1, P2, D2, CHECK, DCHK, END} state_t;

   state_t     state, state_nxt;
   logic [3:0] pc1_nxt, pc2_nxt, pc3_nxt, dc1_nxt, dc2_nxt, dc3_nxt;
   logic [3:0] v;
   logic       ddraw;

   // ranks outside 1..9 (tens, faces, out-of-range codes) are worth nothing
   function automatic logic [3:0] card_value(input logic [3:0] rank);
      return (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
   endfunction

   function automatic logic [3:0] score(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      logic [4:0] s;
      s = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
      return s >= 5'd20 ? 4'(s - 5'd20) : s >= 5'd10 ? 4'(s - 5'd10) : s[3:0];
   endfunction

   assign pscore = score(pcard1, pcard2, pcard3);
   assign dscore = score(dcard1, dcard2, dcard3);

   // dealer third-card table, indexed by dealer two-card score and player third-card value
   assign v     = card_value(pcard3);
   assign ddraw = dscore <= 4'd2 ? 1'b1 :
                  dscore == 4'd3 ? v != 4'd8 :
                  dscore == 4'd4 ? (v >= 4'd2 && v <= 4'd7) :
                  dscore == 4'd5 ? (v >= 4'd4 && v <= 4'd7) :
                  dscore == 4'd6 ? (v >= 4'd6 && v <= 4'd7) : 1'b0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= P1;
         pcard1 <= '0;
         pcard2 <= '0;
         pcard3 <= '0;
         dcard1 <= '0;
         dcard2 <= '0;
         dcard3 <= '0;
      end else if (step) begin
         state  <= state_nxt;
         pcard1 <= pc1_nxt;
         pcard2 <= pc2_nxt;
         pcard3 <= pc3_nxt;
         dcard1 <= dc1_nxt;
         dcard2 <= dc2_nxt;
         dcard3 <= dc3_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc1_nxt   = pcard1;
      pc2_nxt   = pcard2;
      pc3_nxt   = pcard3;
      dc1_nxt   = dcard1;
      dc2_nxt   = dcard2;
      dc3_nxt   = dcard3;
      case (state)
         P1: begin pc1_nxt = new_card; state_nxt = D1; end
         D1: begin dc1_nxt = new_card; state_nxt = P2; end
         P2: begin pc2_nxt = new_card; state_nxt = D2; end
         D2: begin dc2_nxt = new_card; state_nxt = CHECK; end
         CHECK: begin
            if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) state_nxt = END;
            else if (pscore < PLAYER_STAND_MIN) begin
               pc3_nxt   = new_card;
               state_nxt = DCHK;
            end else begin
               // player stands: dealer follows the simple draw-on-5-or-less rule
               dc3_nxt   = dscore <= 4'd5 ? new_card : dcard3;
               state_nxt = END;
            end
         end
         DCHK: begin
            dc3_nxt   = ddraw ? new_card : dcard3;
            state_nxt = END;
         end
         END: begin
            pc1_nxt   = '0;
            pc2_nxt   = '0;
            pc3_nxt   = '0;
            dc1_nxt   = '0;
            dc2_nxt   = '0;
            dc3_nxt   = '0;
            state_nxt = P1;
         end
         default: state_nxt = P1;
      endcase
   end

   // decoded straight from the state register so the downstream bet stage sees a clean edge
   assign endround = state == END;
   assign pwin     = endround && pscore > dscore;
   assign dwin     = endround && pscore < dscore;
   assign tie      = endround && pscore == dscore;

endmodule

// File: tb/tb_baccarat_round_fsm.sv
// tb_baccarat_round_fsm: directed-vector self-checking bench for baccarat_round_fsm
module tb_baccarat_round_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       step = 1'b0;
   logic [3:0] new_card = 4'd0;
   logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
   logic       endround, pwin, dwin, tie;
   int         checks = 0;
   int         errors = 0;
   int         rises = 0;

   baccarat_round_fsm dut (
      .clk(clk), .reset(reset), .step(step), .new_card(new_card),
      .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
      .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
      .pscore(pscore), .dscore(dscore), .endround(endround),
      .pwin(pwin), .dwin(dwin), .tie(tie)
   );

   always #5 clk = ~clk;

   always @(posedge endround) rises++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic deal(input logic [3:0] c);
      @(negedge clk);
      new_card = c;
      step = 1'b1;
      @(posedge clk);
      #1 step = 1'b0;
   endtask

   task automatic hand(input logic [3:0] p1, input logic [3:0] d1, input logic [3:0] p2, input logic [3:0] d2);
      deal(p1);
      deal(d1);
      deal(p2);
      deal(d2);
   endtask

   task automatic res(input string tag, input logic [3:0] ps, input logic [3:0] ds,
                      input logic pw, input logic dw, input logic ti);
      chk({tag, ".pscore"}, pscore, ps);
      chk({tag, ".dscore"}, dscore, ds);
      chk({tag, ".endround"}, endround, 1);
      chk({tag, ".pwin"}, pwin, pw);
      chk({tag, ".dwin"}, dwin, dw);
      chk({tag, ".tie"}, tie, ti);
      chk({tag, ".onehot"}, 32'(pwin) + 32'(dwin) + 32'(tie), 1);
   endtask

   task automatic leave(input string tag);
      deal(4'd0);
      chk({tag, ".exit_end"}, endround, 0);
      chk({tag, ".exit_cards"}, {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
      chk({tag, ".exit_flags"}, {pwin, dwin, tie}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      #1 reset = 1'b0;
      #1;
      chk("rst.cards", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
      chk("rst.scores", {pscore, dscore}, 0);
      chk("rst.flags", {endround, pwin, dwin, tie}, 0);
      @(negedge clk) reset = 1'b1;

      // natural for the player
      hand(4'd9, 4'd3, 4'd13, 4'd2);
      chk("t1.pre_end", endround, 0);
      chk("t1.ps2", pscore, 9);
      chk("t1.ds2", dscore, 5);
      deal(4'd7);
      res("t1", 4'd9, 4'd5, 1, 0, 0);
      chk("t1.pcard3", pcard3, 0);
      chk("t1.dcard3", dcard3, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t1.hold_end", endround, 1);
      chk("t1.rises", rises, 1);
      leave("t1");

      // player draws 7, dealer on 4 draws
      hand(4'd2, 4'd10, 4'd3, 4'd4);
      deal(4'd7);
      chk("t2.pcard3", pcard3, 7);
      chk("t2.ps3", pscore, 2);
      chk("t2.dchk_end", endround, 0);
      deal(4'd1);
      chk("t2.dcard3", dcard3, 1);
      res("t2", 4'd2, 4'd5, 0, 1, 0);
      leave("t2");

      // player stands on 7, dealer on 3 draws
      hand(4'd3, 4'd2, 4'd4, 4'd1);
      deal(4'd5);
      chk("t3.dcard3", dcard3, 5);
      chk("t3.pcard3", pcard3, 0);
      res("t3", 4'd7, 4'd8, 0, 1, 0);
      leave("t3");

      // dealer on 7 never draws
      hand(4'd1, 4'd3, 4'd2, 4'd4);
      deal(4'd8);
      chk("t4.pcard3", pcard3, 8);
      chk("t4.ps3", pscore, 1);
      deal(4'd9);
      chk("t4.dcard3", dcard3, 0);
      res("t4", 4'd1, 4'd7, 0, 1, 0);
      leave("t4");

      // both zero, dealer draws 6
      hand(4'd5, 4'd12, 4'd5, 4'd10);
      deal(4'd10);
      chk("t5a.pcard3", pcard3, 10);
      deal(4'd6);
      chk("t5a.dcard3", dcard3, 6);
      res("t5a", 4'd0, 4'd6, 0, 1, 0);
      leave("t5a");

      // tie at zero
      hand(4'd5, 4'd12, 4'd5, 4'd10);
      deal(4'd10);
      deal(4'd11);
      chk("t5b.dcard3", dcard3, 11);
      res("t5b", 4'd0, 4'd0, 0, 0, 1);
      leave("t5b");

      // out-of-range ranks stored as given and worth 0; dealer natural 9
      hand(4'd14, 4'd15, 4'd8, 4'd9);
      chk("oor.pcard1", pcard1, 14);
      chk("oor.dcard1", dcard1, 15);
      deal(4'd3);
      chk("oor.pcard3", pcard3, 0);
      res("oor", 4'd8, 4'd9, 0, 1, 0);
      leave("oor");

      // step=0 holds mid-round; player stands on 6, dealer 7 stands
      deal(4'd4);
      deal(4'd6);
      new_card = 4'd9;
      repeat (10) @(posedge clk);
      #1;
      chk("hold.pcard1", pcard1, 4);
      chk("hold.dcard1", dcard1, 6);
      chk("hold.pcard2", pcard2, 0);
      deal(4'd2);
      deal(4'd1);
      deal(4'd9);
      chk("hold.pcard3", pcard3, 0);
      chk("hold.dcard3", dcard3, 0);
      res("hold", 4'd6, 4'd7, 0, 1, 0);
      leave("hold");

      // async reset in DCHK
      hand(4'd2, 4'd10, 4'd3, 4'd4);
      deal(4'd7);
      #2 reset = 1'b0;
      #1;
      chk("r6a.cards", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
      chk("r6a.scores", {pscore, dscore}, 0);
      chk("r6a.flags", {endround, pwin, dwin, tie}, 0);
      @(negedge clk) reset = 1'b1;
      new_card = 4'd9;
      repeat (10) @(posedge clk);
      #1;
      chk("r6a.hold", {pcard1, dcard1, pscore, dscore, 3'b000, endround}, 0);

      // async reset while in END
      hand(4'd9, 4'd3, 4'd13, 4'd2);
      deal(4'd0);
      chk("r6b.end", endround, 1);
      #2 reset = 1'b0;
      #1;
      chk("r6b.cards", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
      chk("r6b.scores", {pscore, dscore}, 0);
      chk("r6b.flags", {endround, pwin, dwin, tie}, 0);
      @(negedge clk) reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("r6b.hold", {endround, pcard1, pscore}, 0);

      // fresh round after reset: player 7 stands, dealer 2 draws 3 -> player wins
      hand(4'd4, 4'd1, 4'd3, 4'd1);
      chk("r6c.pcard1", pcard1, 4);
      chk("r6c.dcard2", dcard2, 1);
      deal(4'd3);
      chk("r6c.dcard3", dcard3, 3);
      res("r6c", 4'd7, 4'd5, 1, 0, 0);
      chk("total.rises", rises, 10);
      leave("r6c");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
